// File: rtl/wb_pipe_pkg.sv
// Shared encodings for the writeback bypass pipe: load sizes and load-slot FSM states.
package wb_pipe_pkg;

  localparam int unsigned XLEN_DEF = 64;
  localparam int unsigned RAW_DEF  = 5;

  typedef enum logic [1:0] {
    LS_B = 2'd0,
    LS_H = 2'd1,
    LS_W = 2'd2,
    LS_D = 2'd3
  } load_size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/wb_bypass_pipe_if.sv
// EXU / data-bus inputs and forwarding / register-file outputs of the bypass pipe.
interface wb_bypass_pipe_if
  import wb_pipe_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned RAW  = RAW_DEF
);

  // EXU side
  logic            exu_valid;
  logic            exu_op_load;
  logic [RAW-1:0]  exu_rd;
  logic            exu_rf_we;
  logic [XLEN-1:0] exu_rd_dat;
  logic [1:0]      exu_load_size;
  logic            exu_load_unsigned;
  logic [2:0]      exu_addr_lo;
  logic            flush;

  // Data-bus load response
  logic            dbus_rvalid;
  logic [XLEN-1:0] dbus_rdata;

  logic            o_stall;

  // Forwarding listener buses
  logic            fwd_exu_op_load;
  logic [RAW-1:0]  fwd_exu_rd;
  logic            fwd_exu_rf_we;
  logic [XLEN-1:0] fwd_exu_rd_dat;

  logic            fwd_lsu_op_load;
  logic [RAW-1:0]  fwd_lsu_rd;
  logic            fwd_lsu_rf_we;
  logic [XLEN-1:0] fwd_lsu_rd_dat;
  logic [XLEN-1:0] fwd_lsu_lsu_dat;

  logic [RAW-1:0]  fwd_wb_rd;
  logic            fwd_wb_rf_we;
  logic [XLEN-1:0] fwd_wb_rd_dat;

  // Register-file write port
  logic            rf_we;
  logic [RAW-1:0]  rf_waddr;
  logic [XLEN-1:0] rf_wdat;

  modport slave (
    input  exu_valid, exu_op_load, exu_rd, exu_rf_we, exu_rd_dat,
           exu_load_size, exu_load_unsigned, exu_addr_lo, flush,
           dbus_rvalid, dbus_rdata,
    output o_stall,
           fwd_exu_op_load, fwd_exu_rd, fwd_exu_rf_we, fwd_exu_rd_dat,
           fwd_lsu_op_load, fwd_lsu_rd, fwd_lsu_rf_we, fwd_lsu_rd_dat, fwd_lsu_lsu_dat,
           fwd_wb_rd, fwd_wb_rf_we, fwd_wb_rd_dat,
           rf_we, rf_waddr, rf_wdat
  );

  modport master (
    output exu_valid, exu_op_load, exu_rd, exu_rf_we, exu_rd_dat,
           exu_load_size, exu_load_unsigned, exu_addr_lo, flush,
           dbus_rvalid, dbus_rdata,
    input  o_stall,
           fwd_exu_op_load, fwd_exu_rd, fwd_exu_rf_we, fwd_exu_rd_dat,
           fwd_lsu_op_load, fwd_lsu_rd, fwd_lsu_rf_we, fwd_lsu_rd_dat, fwd_lsu_lsu_dat,
           fwd_wb_rd, fwd_wb_rf_we, fwd_wb_rd_dat,
           rf_we, rf_waddr, rf_wdat
  );

endinterface

// File: rtl/load_extend.sv
// Load byte-lane extraction and sign/zero extension from an aligned doubleword.
module load_extend
  import wb_pipe_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  input  logic [2:0]      addr_lo_i,
  output logic [XLEN-1:0] result_o
);

  logic [2:0]      lane_c;
  logic [XLEN-1:0] shifted_c;
  logic            sx_c;

  // Align the addressed lane to bit 0, then extend from the access width
  always_comb begin
    case (load_size_e'(size_i))
      LS_B:    lane_c = addr_lo_i;
      LS_H:    lane_c = {addr_lo_i[2:1], 1'b0};
      LS_W:    lane_c = {addr_lo_i[2], 2'b00};
      default: lane_c = 3'd0;
    endcase
    shifted_c = rdata_i >> {lane_c, 3'b000};
    sx_c      = 1'b0;
    result_o  = shifted_c;
    case (load_size_e'(size_i))
      LS_B: begin
        sx_c     = ~unsigned_i & shifted_c[7];
        result_o = {{(XLEN-8){sx_c}}, shifted_c[7:0]};
      end
      LS_H: begin
        sx_c     = ~unsigned_i & shifted_c[15];
        result_o = {{(XLEN-16){sx_c}}, shifted_c[15:0]};
      end
      LS_W: begin
        sx_c     = ~unsigned_i & shifted_c[31];
        result_o = {{(XLEN-32){sx_c}}, shifted_c[31:0]};
      end
      default: result_o = shifted_c;
    endcase
  end

endmodule

// File: rtl/wb_bypass_pipe.sv
// LSU and WB pipeline registers feeding the operand-forwarding buses and register-file write port.
module wb_bypass_pipe
  import wb_pipe_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned RAW  = RAW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  wb_bypass_pipe_if.slave bus
);

  state_e          state_q, state_d;

  logic            lsu_valid_q, lsu_valid_d;
  logic            lsu_rf_we_q, lsu_rf_we_d;
  logic            lsu_op_load_q, lsu_op_load_d;
  logic [RAW-1:0]  lsu_rd_q, lsu_rd_d;
  logic [XLEN-1:0] lsu_rd_dat_q, lsu_rd_dat_d;
  logic [XLEN-1:0] lsu_dat_q, lsu_dat_d;
  logic [1:0]      lsu_size_q, lsu_size_d;
  logic            lsu_unsigned_q, lsu_unsigned_d;
  logic [2:0]      lsu_addr_lo_q, lsu_addr_lo_d;

  logic            wb_valid_q, wb_valid_d;
  logic            wb_rf_we_q, wb_rf_we_d;
  logic [RAW-1:0]  wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_dat_q, wb_dat_d;

  logic            stall_c;
  logic            exu_live_c;
  logic            exu_load_c;
  logic            wb_we_c;
  logic [XLEN-1:0] ext_c;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .rdata_i    (bus.dbus_rdata),
    .size_i     (lsu_size_q),
    .unsigned_i (lsu_unsigned_q),
    .addr_lo_i  (lsu_addr_lo_q),
    .result_o   (ext_c)
  );

  // Stall while a load sits in LSU without its response; derived only from registers
  assign stall_c    = lsu_valid_q & lsu_op_load_q & (state_q != S_DONE);
  assign exu_live_c = bus.exu_valid & ~bus.flush;
  assign exu_load_c = exu_live_c & bus.exu_op_load;

  // Next-state for the load FSM and the LSU/WB pipeline registers
  always_comb begin
    state_d        = state_q;
    lsu_valid_d    = lsu_valid_q;
    lsu_rf_we_d    = lsu_rf_we_q;
    lsu_op_load_d  = lsu_op_load_q;
    lsu_rd_d       = lsu_rd_q;
    lsu_rd_dat_d   = lsu_rd_dat_q;
    lsu_dat_d      = lsu_dat_q;
    lsu_size_d     = lsu_size_q;
    lsu_unsigned_d = lsu_unsigned_q;
    lsu_addr_lo_d  = lsu_addr_lo_q;
    wb_valid_d     = wb_valid_q;
    wb_rf_we_d     = wb_rf_we_q;
    wb_rd_d        = wb_rd_q;
    wb_dat_d       = wb_dat_q;

    if (!stall_c) begin
      // Flushed or invalid EXU slots enter LSU as bubbles
      lsu_valid_d    = exu_live_c;
      lsu_rf_we_d    = exu_live_c & bus.exu_rf_we;
      lsu_op_load_d  = exu_load_c;
      lsu_rd_d       = bus.exu_rd;
      lsu_rd_dat_d   = bus.exu_rd_dat;
      lsu_size_d     = bus.exu_load_size;
      lsu_unsigned_d = bus.exu_load_unsigned;
      lsu_addr_lo_d  = bus.exu_addr_lo;
      wb_valid_d     = lsu_valid_q;
      wb_rf_we_d     = lsu_rf_we_q;
      wb_rd_d        = lsu_rd_q;
      wb_dat_d       = lsu_op_load_q ? lsu_dat_q : lsu_rd_dat_q;
    end else begin
      // Held LSU instruction must not write twice
      wb_valid_d = 1'b0;
      wb_rf_we_d = 1'b0;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (!stall_c) state_d = exu_load_c ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        if (bus.dbus_rvalid) begin
          state_d   = S_DONE;
          lsu_dat_d = ext_c;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      lsu_valid_q    <= 1'b0;
      lsu_rf_we_q    <= 1'b0;
      lsu_op_load_q  <= 1'b0;
      lsu_rd_q       <= '0;
      lsu_rd_dat_q   <= '0;
      lsu_dat_q      <= '0;
      lsu_size_q     <= 2'd0;
      lsu_unsigned_q <= 1'b0;
      lsu_addr_lo_q  <= 3'd0;
      wb_valid_q     <= 1'b0;
      wb_rf_we_q     <= 1'b0;
      wb_rd_q        <= '0;
      wb_dat_q       <= '0;
    end else begin
      state_q        <= state_d;
      lsu_valid_q    <= lsu_valid_d;
      lsu_rf_we_q    <= lsu_rf_we_d;
      lsu_op_load_q  <= lsu_op_load_d;
      lsu_rd_q       <= lsu_rd_d;
      lsu_rd_dat_q   <= lsu_rd_dat_d;
      lsu_dat_q      <= lsu_dat_d;
      lsu_size_q     <= lsu_size_d;
      lsu_unsigned_q <= lsu_unsigned_d;
      lsu_addr_lo_q  <= lsu_addr_lo_d;
      wb_valid_q     <= wb_valid_d;
      wb_rf_we_q     <= wb_rf_we_d;
      wb_rd_q        <= wb_rd_d;
      wb_dat_q       <= wb_dat_d;
    end
  end

  // x0 is hardwired, so writes to it are dropped at the port
  assign wb_we_c = wb_valid_q & wb_rf_we_q & (|wb_rd_q);

  assign bus.o_stall         = stall_c;

  assign bus.fwd_exu_op_load = bus.exu_op_load;
  assign bus.fwd_exu_rd      = bus.exu_rd;
  assign bus.fwd_exu_rf_we   = bus.exu_valid & bus.exu_rf_we & ~bus.flush;
  assign bus.fwd_exu_rd_dat  = bus.exu_rd_dat;

  assign bus.fwd_lsu_op_load = lsu_op_load_q;
  assign bus.fwd_lsu_rd      = lsu_rd_q;
  assign bus.fwd_lsu_rf_we   = lsu_valid_q & lsu_rf_we_q;
  assign bus.fwd_lsu_rd_dat  = lsu_rd_dat_q;
  assign bus.fwd_lsu_lsu_dat = lsu_dat_q;

  assign bus.fwd_wb_rd       = wb_rd_q;
  assign bus.fwd_wb_rf_we    = wb_we_c;
  assign bus.fwd_wb_rd_dat   = wb_dat_q;

  assign bus.rf_we           = wb_we_c;
  assign bus.rf_waddr        = wb_rd_q;
  assign bus.rf_wdat         = wb_dat_q;

endmodule

// File: tb/tb_wb_bypass_pipe.sv
// Bench for wb_bypass_pipe: vector table, load/reset sequences, randomized run against a write-order model.
module tb_wb_bypass_pipe;

  localparam int unsigned XLEN = 64;
  localparam int unsigned RAW  = 5;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  wb_bypass_pipe_if #(.XLEN(XLEN), .RAW(RAW)) bus ();

  wb_bypass_pipe #(.XLEN(XLEN), .RAW(RAW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        v;
    logic        ld;
    logic        we;
    logic        uns;
    logic [4:0]  rd;
    logic [63:0] dat;
    logic [1:0]  sz;
    logic [2:0]  a;
  } ins_t;

  typedef struct packed {
    logic        v;
    logic        fl;
    logic        we;
    logic [4:0]  rd;
    logic [63:0] dat;
    logic        e_exu_we;
    logic        e_lsu_we;
    logic        e_rf_we;
  } vec_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] dat;
  } wr_t;

  int n_err;
  int n_chk;

  vec_t vecs [6];

  // Reference model: expected register-file writes in program order
  wr_t  exp_q [$];
  ins_t cur;
  logic need_new;
  logic outst;
  logic ld_wr;
  ins_t ld_ins;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h want 0x%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input ins_t i, input logic fl);
    bus.exu_valid         = i.v;
    bus.exu_op_load       = i.ld;
    bus.exu_rf_we         = i.we;
    bus.exu_load_unsigned = i.uns;
    bus.exu_rd            = i.rd;
    bus.exu_rd_dat        = i.dat;
    bus.exu_load_size     = i.sz;
    bus.exu_addr_lo       = i.a;
    bus.flush             = fl;
  endtask

  task automatic idle();
    drive('0, 1'b0);
    bus.dbus_rvalid = 1'b0;
    bus.dbus_rdata  = '0;
  endtask

  // Load result from plain arithmetic on access width and offset
  function automatic logic [63:0] m_ext(input logic [63:0] d, input logic [1:0] sz,
                                        input logic uns, input logic [2:0] a);
    int nb;
    int off;
    logic [63:0] v;
    logic [63:0] mask;
    nb  = 1 << sz;
    off = (int'(a) / nb) * nb;
    v   = d >> (8 * off);
    if (nb < 8) begin
      mask = (64'd1 << (8 * nb)) - 64'd1;
      v    = v & mask;
      if (!uns && v[8*nb-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic ins_t rand_ins();
    ins_t i;
    i.v   = ($urandom_range(9) < 8);
    i.ld  = ($urandom_range(9) < 3);
    i.we  = ($urandom_range(9) < 8);
    i.uns = 1'($urandom_range(1));
    i.rd  = 5'($urandom_range(31));
    i.dat = {$urandom, $urandom};
    i.sz  = 2'($urandom_range(3));
    i.a   = 3'($urandom_range(7));
    return i;
  endfunction

  // One randomized cycle: stall and write-order checks, then model update for the coming edge
  task automatic rnd_cycle(input logic gen);
    logic        fl;
    logic        rv;
    logic        stall_now;
    logic [63:0] rdat;
    wr_t         w;
    if (!gen) cur = '0;
    else if (need_new) cur = rand_ins();
    fl = gen && ($urandom_range(9) == 0);
    if (outst) rv = gen ? ($urandom_range(2) == 0) : 1'b1;
    else       rv = gen && ($urandom_range(7) == 0);
    rdat = {$urandom, $urandom};
    drive(cur, fl);
    bus.dbus_rvalid = rv;
    bus.dbus_rdata  = rdat;
    @(negedge clk);
    chk("rnd_stall", 64'(bus.o_stall), 64'(outst));
    chk("rnd_exu_we", 64'(bus.fwd_exu_rf_we), 64'(cur.v & cur.we & ~fl));
    if (bus.rf_we) begin
      if (exp_q.size() == 0) begin
        chk("rnd_spurious_we", 64'(bus.rf_we), 64'd0);
      end else begin
        w = exp_q.pop_front();
        chk("rnd_waddr", 64'(bus.rf_waddr), 64'(w.rd));
        chk("rnd_wdat", bus.rf_wdat, w.dat);
      end
    end
    stall_now = outst;
    if (stall_now && rv) begin
      outst = 1'b0;
      if (ld_wr) exp_q.push_back('{ld_ins.rd, m_ext(rdat, ld_ins.sz, ld_ins.uns, ld_ins.a)});
      ld_wr = 1'b0;
    end
    if (!stall_now && cur.v && !fl) begin
      if (cur.ld) begin
        outst  = 1'b1;
        ld_ins = cur;
        ld_wr  = cur.we && (cur.rd != 5'd0);
      end else if (cur.we && cur.rd != 5'd0) begin
        exp_q.push_back('{cur.rd, cur.dat});
      end
    end
    need_new = fl || !stall_now;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_err    = 0;
    n_chk    = 0;
    need_new = 1'b1;
    outst    = 1'b0;
    ld_wr    = 1'b0;
    ld_ins   = '0;
    cur      = '0;
    rst_n    = 1'b0;
    idle();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_stall", 64'(bus.o_stall), 64'd0);
    chk("rst_lsu_we", 64'(bus.fwd_lsu_rf_we), 64'd0);
    chk("rst_wb_we", 64'(bus.fwd_wb_rf_we), 64'd0);
    chk("rst_rf_we", 64'(bus.rf_we), 64'd0);
    chk("rst_lsu_dat", bus.fwd_lsu_lsu_dat, 64'd0);
    chk("rst_wb_dat", bus.fwd_wb_rd_dat, 64'd0);
    rst_n = 1'b1;
    cyc();

    // ALU vectors: {valid, flush, we, rd, data, exp exu_we, exp lsu_we, exp rf_we}
    vecs[0] = '{1'b1, 1'b0, 1'b1, 5'd5,  64'h11,                  1'b1, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 5'd7,  64'hDEAD,                1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 5'd0,  64'h55,                  1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 5'd9,  64'h99,                  1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 5'd3,  64'h33,                  1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 6; k++) begin
      drive('{vecs[k].v, 1'b0, vecs[k].we, 1'b0, vecs[k].rd, vecs[k].dat, 2'd0, 3'd0}, vecs[k].fl);
      @(negedge clk);
      chk($sformatf("v%0d_exu_we", k), 64'(bus.fwd_exu_rf_we), 64'(vecs[k].e_exu_we));
      chk($sformatf("v%0d_exu_rd", k), 64'(bus.fwd_exu_rd), 64'(vecs[k].rd));
      chk($sformatf("v%0d_exu_dat", k), bus.fwd_exu_rd_dat, vecs[k].dat);
      chk($sformatf("v%0d_exu_ld", k), 64'(bus.fwd_exu_op_load), 64'd0);
      chk($sformatf("v%0d_stall", k), 64'(bus.o_stall), 64'd0);
      cyc();
      idle();
      @(negedge clk);
      chk($sformatf("v%0d_lsu_we", k), 64'(bus.fwd_lsu_rf_we), 64'(vecs[k].e_lsu_we));
      if (vecs[k].e_lsu_we) begin
        chk($sformatf("v%0d_lsu_rd", k), 64'(bus.fwd_lsu_rd), 64'(vecs[k].rd));
        chk($sformatf("v%0d_lsu_dat", k), bus.fwd_lsu_rd_dat, vecs[k].dat);
      end
      cyc();
      @(negedge clk);
      chk($sformatf("v%0d_rf_we", k), 64'(bus.rf_we), 64'(vecs[k].e_rf_we));
      chk($sformatf("v%0d_wb_we", k), 64'(bus.fwd_wb_rf_we), 64'(vecs[k].e_rf_we));
      if (vecs[k].e_rf_we) begin
        chk($sformatf("v%0d_waddr", k), 64'(bus.rf_waddr), 64'(vecs[k].rd));
        chk($sformatf("v%0d_wdat", k), bus.rf_wdat, vecs[k].dat);
        chk($sformatf("v%0d_wb_rd", k), 64'(bus.fwd_wb_rd), 64'(vecs[k].rd));
        chk($sformatf("v%0d_wb_dat", k), bus.fwd_wb_rd_dat, vecs[k].dat);
      end
      cyc();
    end

    // Signed byte load, offset 3, response two cycles after entering LSU
    drive('{1'b1, 1'b1, 1'b1, 1'b0, 5'd10, 64'h0, 2'd0, 3'd3}, 1'b0);
    cyc();
    idle();
    @(negedge clk);
    chk("sb_stall0", 64'(bus.o_stall), 64'd1);
    chk("sb_lsu_ld", 64'(bus.fwd_lsu_op_load), 64'd1);
    chk("sb_lsu_we", 64'(bus.fwd_lsu_rf_we), 64'd1);
    cyc();
    @(negedge clk);
    chk("sb_stall1", 64'(bus.o_stall), 64'd1);
    cyc();
    bus.dbus_rvalid = 1'b1;
    bus.dbus_rdata  = 64'h0000_0000_8000_0000;
    @(negedge clk);
    chk("sb_stall2", 64'(bus.o_stall), 64'd1);
    cyc();
    bus.dbus_rvalid = 1'b0;
    bus.dbus_rdata  = 64'h1234_5678_9ABC_DEF0;
    @(negedge clk);
    chk("sb_stall3", 64'(bus.o_stall), 64'd0);
    chk("sb_lsu_dat", bus.fwd_lsu_lsu_dat, 64'hFFFF_FFFF_FFFF_FF80);
    chk("sb_rf_we3", 64'(bus.rf_we), 64'd0);
    cyc();
    @(negedge clk);
    chk("sb_rf_we4", 64'(bus.rf_we), 64'd1);
    chk("sb_waddr", 64'(bus.rf_waddr), 64'd10);
    chk("sb_wdat", bus.rf_wdat, 64'hFFFF_FFFF_FFFF_FF80);
    chk("sb_wb_dat", bus.fwd_wb_rd_dat, 64'hFFFF_FFFF_FFFF_FF80);
    cyc();
    @(negedge clk);
    chk("sb_rf_we5", 64'(bus.rf_we), 64'd0);
    cyc();

    // Unsigned half load, offset 6, with an ALU op waiting behind it
    drive('{1'b1, 1'b1, 1'b1, 1'b1, 5'd12, 64'h0, 2'd1, 3'd6}, 1'b0);
    cyc();
    drive('{1'b1, 1'b0, 1'b1, 1'b0, 5'd13, 64'h77, 2'd0, 3'd0}, 1'b0);
    @(negedge clk);
    chk("uh_stall0", 64'(bus.o_stall), 64'd1);
    cyc();
    bus.dbus_rvalid = 1'b1;
    bus.dbus_rdata  = 64'hBEEF_0000_0000_0000;
    @(negedge clk);
    chk("uh_stall1", 64'(bus.o_stall), 64'd1);
    chk("uh_lsu_rd1", 64'(bus.fwd_lsu_rd), 64'd12);
    cyc();
    bus.dbus_rvalid = 1'b0;
    @(negedge clk);
    chk("uh_stall2", 64'(bus.o_stall), 64'd0);
    chk("uh_lsu_rd2", 64'(bus.fwd_lsu_rd), 64'd12);
    chk("uh_rf_we2", 64'(bus.rf_we), 64'd0);
    cyc();
    idle();
    @(negedge clk);
    chk("uh_rf_we3", 64'(bus.rf_we), 64'd1);
    chk("uh_waddr3", 64'(bus.rf_waddr), 64'd12);
    chk("uh_wdat3", bus.rf_wdat, 64'h0000_0000_0000_BEEF);
    chk("uh_lsu_rd3", 64'(bus.fwd_lsu_rd), 64'd13);
    chk("uh_lsu_dat3", bus.fwd_lsu_rd_dat, 64'h77);
    cyc();
    @(negedge clk);
    chk("uh_rf_we4", 64'(bus.rf_we), 64'd1);
    chk("uh_waddr4", 64'(bus.rf_waddr), 64'd13);
    chk("uh_wdat4", bus.rf_wdat, 64'h77);
    cyc();
    @(negedge clk);
    chk("uh_rf_we5", 64'(bus.rf_we), 64'd0);
    cyc();

    // Reset while waiting on a load, then a stray response
    drive('{1'b1, 1'b1, 1'b1, 1'b0, 5'd20, 64'h0, 2'd3, 3'd0}, 1'b0);
    cyc();
    idle();
    @(negedge clk);
    chk("rw_stall0", 64'(bus.o_stall), 64'd1);
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rw_stall_rst", 64'(bus.o_stall), 64'd0);
    chk("rw_lsu_we_rst", 64'(bus.fwd_lsu_rf_we), 64'd0);
    chk("rw_wb_we_rst", 64'(bus.fwd_wb_rf_we), 64'd0);
    chk("rw_rf_we_rst", 64'(bus.rf_we), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    bus.dbus_rvalid = 1'b1;
    bus.dbus_rdata  = 64'hA5A5_A5A5_A5A5_A5A5;
    @(negedge clk);
    chk("rw_stray_stall", 64'(bus.o_stall), 64'd0);
    cyc();
    bus.dbus_rvalid = 1'b0;
    @(negedge clk);
    chk("rw_stray_dat", bus.fwd_lsu_lsu_dat, 64'd0);
    chk("rw_stray_rf_we", 64'(bus.rf_we), 64'd0);
    chk("rw_stray_stall2", 64'(bus.o_stall), 64'd0);
    cyc();
    drive('{1'b1, 1'b0, 1'b1, 1'b0, 5'd4, 64'h44, 2'd0, 3'd0}, 1'b0);
    cyc();
    idle();
    @(negedge clk);
    chk("rw_alu_stall", 64'(bus.o_stall), 64'd0);
    chk("rw_alu_lsu_rd", 64'(bus.fwd_lsu_rd), 64'd4);
    cyc();
    @(negedge clk);
    chk("rw_alu_rf_we", 64'(bus.rf_we), 64'd1);
    chk("rw_alu_waddr", 64'(bus.rf_waddr), 64'd4);
    chk("rw_alu_wdat", bus.rf_wdat, 64'h44);
    cyc();
    @(negedge clk);
    cyc();

    // Randomized traffic, then drain
    for (int c = 0; c < 500; c++) rnd_cycle(1'b1);
    for (int c = 0; c < 20; c++) rnd_cycle(1'b0);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
